adc_sample_buffer: RTL and testbench

- Downstream consumer of the 12-bit ADC serial reader in the Data_Collector path.
- On a start command it captures DEPTH consecutive 12-bit samples into on-chip memory and tracks the running minimum and maximum.
- It then holds the record for readout by the host-side logic through a one-word-per-request read handshake.
- Used to compare twinned circuits: one record per capture window.

---
 rtl/adc_sample_buffer.sv | 126 ++++++++++++
 tb/tb_adc_sample_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_buffer.sv
// rtl/adc_sample_buffer.sv - capture one DEPTH-sample ADC record with min/max tracking and word-per-request readout
module adc_sample_buffer #(
   parameter int DATA_W = 12,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic [DATA_W-1:0] min_val,
   output logic [DATA_W-1:0] max_val,
   output logic              overrun
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   FULL      = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic restart;
   logic wr_fire;
   logic rd_fire;

   // start restarts from IDLE or DONE; it wins over a same-cycle read and ignores a same-cycle sample
   assign restart = start && (state != S_CAPTURE);
   assign wr_fire = (state == S_CAPTURE) && sample_valid;
   assign rd_fire = (state == S_DONE) && rd_en && !start;

   // control FSM with registered status outputs, pointers and running min/max
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         min_val  <= '1;
         max_val  <= '0;
         overrun  <= 1'b0;
      end else begin
         rd_valid <= rd_fire;
         if (restart) begin
            state   <= S_CAPTURE;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            min_val <= '1;
            max_val <= '0;
            overrun <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  busy <= 1'b0;
                  done <= 1'b0;
               end
               S_CAPTURE: begin
                  if (sample_valid) begin
                     wptr  <= wptr + 1'b1;
                     count <= count + 1'b1;
                     if (sample_in < min_val) min_val <= sample_in;
                     if (sample_in > max_val) max_val <= sample_in;
                     // the write that fills the record hands it over to readout
                     if (count == FULL - 1'b1) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
               S_DONE: begin
                  if (rd_en) begin
                     rptr <= rptr + 1'b1;
                     if (rptr == LAST_ADDR) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                     end
                  end
                  // late samples are dropped but flagged until the next start
                  if (sample_valid) overrun <= 1'b1;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            endcase
         end
      end
   end

   // sample memory write port, contents intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wptr] <= sample_in;
   end

   // registered read port, one cycle latency, holds last word between reads
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (rd_fire) begin
         rd_data <= mem[rptr];
      end
   end

endmodule

// File: tb/tb_adc_sample_buffer.sv
// tb/tb_adc_sample_buffer.sv - self-checking bench for adc_sample_buffer against a record-level model
module tb_adc_sample_buffer;

   localparam int DW    = 12;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] sample_in;
   logic          sample_valid;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;
   logic          done;
   logic [8:0]    count;
   logic [DW-1:0] min_val;
   logic [DW-1:0] max_val;
   logic          overrun;

   int n_pass  = 0;
   int n_total = 0;

   adc_sample_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .busy         (busy),
      .done         (done),
      .count        (count),
      .min_val      (min_val),
      .max_val      (max_val),
      .overrun      (overrun)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
   endtask

   // record-level model: mode 0 = idle, 1 = capturing, 2 = record held for readout
   int            m_mode   = 0;
   int            m_n      = 0;
   int            m_nread  = 0;
   logic          m_over   = 1'b0;
   logic          m_rvalid = 1'b0;
   logic [DW-1:0] m_rdata  = '0;
   logic [DW-1:0] m_rec [DEPTH];

   function automatic logic [DW-1:0] rec_min();
      logic [DW-1:0] r = '1;
      for (int i = 0; i < m_n; i++) if (m_rec[i] < r) r = m_rec[i];
      return r;
   endfunction

   function automatic logic [DW-1:0] rec_max();
      logic [DW-1:0] r = '0;
      for (int i = 0; i < m_n; i++) if (m_rec[i] > r) r = m_rec[i];
      return r;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode   <= 0;
         m_n      <= 0;
         m_nread  <= 0;
         m_over   <= 1'b0;
         m_rvalid <= 1'b0;
         m_rdata  <= '0;
      end else begin
         m_rvalid <= 1'b0;
         if (start && m_mode != 1) begin
            m_mode <= 1;
            m_n    <= 0;
            m_over <= 1'b0;
         end else if (m_mode == 1) begin
            if (sample_valid) begin
               m_rec[m_n] <= sample_in;
               m_n        <= m_n + 1;
               if (m_n + 1 == DEPTH) begin
                  m_mode  <= 2;
                  m_nread <= 0;
               end
            end
         end else if (m_mode == 2) begin
            if (rd_en) begin
               m_rdata  <= m_rec[m_nread];
               m_rvalid <= 1'b1;
               m_nread  <= m_nread + 1;
               if (m_nread + 1 == DEPTH) m_mode <= 0;
            end
            if (sample_valid) m_over <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy", busy, m_mode == 1);
      chk("done", done, m_mode == 2);
      chk("count", count, m_n);
      chk("min_val", min_val, rec_min());
      chk("max_val", max_val, rec_max());
      chk("overrun", overrun, m_over);
      chk("rd_valid", rd_valid, m_rvalid);
      if (m_rvalid) chk("rd_data", rd_data, m_rdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [DW-1:0] v, input int gap);
      sample_in    = v;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      repeat (gap - 1) tick();
   endtask

   logic [DW-1:0] ext [4] = '{12'h800, 12'hFFF, 12'h000, 12'h7FF};

   initial begin
      rst          = 1'b0;
      start        = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      rd_en        = 1'b0;
      repeat (3) tick();
      chk("reset_count", count, 0);
      chk("reset_min", min_val, 12'hFFF);
      chk("reset_max", max_val, 0);
      chk("reset_rd_data", rd_data, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      rst = 1'b1;
      tick();

      // idle ignores samples and reads
      sample_in = 12'h055; sample_valid = 1'b1; rd_en = 1'b1;
      tick();
      sample_valid = 1'b0; rd_en = 1'b0;
      tick();
      chk("idle_count", count, 0);
      chk("idle_rd_valid", rd_valid, 0);

      // start coincident with a sample: that sample is not stored
      start = 1'b1; sample_valid = 1'b1; sample_in = 12'h123;
      tick();
      start = 1'b0; sample_valid = 1'b0;
      chk("start_coinc_count", count, 0);
      chk("start_coinc_busy", busy, 1);

      // min/max extremes
      for (int i = 0; i < 4; i++) strobe(ext[i], 3);
      chk("ext_min", min_val, 12'h000);
      chk("ext_max", max_val, 12'hFFF);
      chk("ext_count", count, 4);

      // fill to 100 samples, then abort with reset
      for (int i = 4; i < 100; i++) strobe(12'(i + 12'h100), 1);
      chk("pre_abort_count", count, 100);
      rst = 1'b0;
      #1;
      chk("abort_count", count, 0);
      chk("abort_busy", busy, 0);
      chk("abort_min", min_val, 12'hFFF);
      chk("abort_max", max_val, 0);
      tick();
      rst = 1'b1;
      tick();

      // full ramp capture with wide spacing
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         sample_in = 12'(i); sample_valid = 1'b1;
         tick();
         sample_valid = 1'b0;
         chk("ramp_done", done, i == DEPTH - 1);
         chk("ramp_busy", busy, i != DEPTH - 1);
         repeat (63) tick();
      end
      chk("ramp_count", count, 256);
      chk("ramp_min", min_val, 0);
      chk("ramp_max", max_val, 255);

      // late sample in DONE
      sample_in = 12'hABC; sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      chk("overrun_set", overrun, 1);
      chk("overrun_count", count, 256);
      chk("overrun_max", max_val, 255);

      // back-to-back readout plus one extra request
      rd_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         chk("read_valid", rd_valid, 1);
         chk("read_data", rd_data, i);
         chk("read_done", done, i != DEPTH - 1);
      end
      tick();
      chk("extra_read_valid", rd_valid, 0);
      rd_en = 1'b0;
      tick();
      chk("hold_count", count, 256);
      chk("hold_min", min_val, 0);
      chk("hold_max", max_val, 255);

      // second record, back-to-back samples with a scattered pattern
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < DEPTH; i++) strobe(12'((i * 37 + 5) ^ (i << 4)), 1);
      chk("rec2_done", done, 1);

      // gapped reads, then a late sample, then start+rd_en together
      rd_en = 1'b1; tick(); tick();
      rd_en = 1'b0; tick();
      rd_en = 1'b1; tick();
      rd_en = 1'b0;
      sample_valid = 1'b1; tick();
      sample_valid = 1'b0;
      chk("rec2_overrun", overrun, 1);
      start = 1'b1; rd_en = 1'b1;
      tick();
      start = 1'b0; rd_en = 1'b0;
      chk("start_rd_valid", rd_valid, 0);
      chk("start_rd_busy", busy, 1);
      chk("start_rd_overrun", overrun, 0);
      chk("start_rd_count", count, 0);
      strobe(12'h3C3, 2);
      strobe(12'h0F0, 2);
      chk("rec3_min", min_val, 12'h0F0);
      chk("rec3_max", max_val, 12'h3C3);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
